rca_seq_ctrl: RTL
=================

// Module: rca_seq_ctrl
// PURPOSE
//  Multi-cycle wide-adder controller: adds W-bit operands by sequencing one narrow
//  CHUNK-bit ripple-carry slice over N=W/CHUNK cycles, LSB chunk first.
//  Trades latency for area against the flat RCA16/32/64 adders.
//  Valid/ready on both sides, so it drops into any pipelined datapath.
// PARAMETERS
//  W      64  operand/result width
//  CHUNK  8   ripple slice width; W%CHUNK!=0 or CHUNK>W -> elaboration error
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand request
//  in_ready   out  1      high only in IDLE
//  a          in   W      operand A, sampled at accept
//  b          in   W      operand B, sampled at accept
//  cin        in   1      carry-in, sampled at accept
//  sub        in   1      subtract select (only with RCA_SEQ_SUB_EN)
//  out_valid  out  1      result available (DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  W      result; meaningful only while out_valid=1
//  cout       out  1      final carry-out; meaningful only while out_valid=1
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async assert, sync-free release): state=IDLE, in_ready=1, out_valid=0,
//    busy=0, sum=0, cout=0, chunk counter=0, carry reg=0.
//  - FSM: IDLE -(in_valid&in_ready)-> RUN -(cnt==N-1)-> DONE -(out_ready)-> IDLE.
//  - Accept edge: latch a,b into shift regs; carry reg<=cin; cnt<=0.
//  - Each RUN edge: slice adds low CHUNK of a_sh,b_sh + carry reg; result chunk
//    shifts into sum_sh from MSB end; a_sh/b_sh shift right by CHUNK;
//    carry reg<=slice cout; cnt++.
//  - Latency: out_valid rises exactly N cycles after the accept edge
//    (N=1 -> single RUN cycle). Min initiation interval N+2 cycles.
//  - DONE: sum, cout, out_valid held stable until out_ready=1; then IDLE.
//  - in_valid while RUN/DONE is ignored (no accept, no queueing);
//    a/b/cin changes after accept do not affect the result.
//  - Result = (a+b+cin) mod 2^W; cout = bit W of the full sum.
//  - rst_n low mid-RUN/DONE: operation aborted, no out_valid, reset values at once.
// CONFIGURATION
//  RCA_SEQ_SUB_EN defined: sub port present; sub sampled at accept; sub=1 ->
//   b latched inverted, carry reg<=1 (cin ignored): sum=a-b, cout=1 means no borrow.
//  Undefined: no sub port; add only.
// STRUCTURE
//  rca_seq_pkg: state enum (IDLE,RUN,DONE), N=W/CHUNK and counter-width localparam
//   as functions of W,CHUNK.
//  Sub-module rca_slice: CHUNK-bit ripple adder with carry-in, chained from FA cells
//   (existing RCA8 lacks cin, so not reused directly).
//  Top: FSM, counter, operand/sum shift regs, carry reg.
// TESTING  (W=64, CHUNK=8, N=8)
//  1. a=998,b=128,cin=0 -> sum=1126,cout=0; out_valid exactly 8 cycles after accept.
//  2. a=64'hFFFF_FFFF_FFFF_FFFF,b=1,cin=0 -> sum=0,cout=1 (carry crosses all 8 chunks).
//  3. a=0,b=0,cin=1 -> sum=1,cout=0; then out_ready=0 for 5 cycles -> sum/out_valid
//     held, in_ready=0, concurrent in_valid with a=7 not accepted; accepted after IDLE.
//  4. rst_n pulsed low during 3rd RUN cycle -> out_valid=0,sum=0,busy=0 immediately;
//     in_ready=1 after release; next op (a=9998,b=9028) -> 19026.
//  5. RCA_SEQ_SUB_EN: a=9998,b=9028,sub=1 -> 970,cout=1; a=5,b=7,sub=1 ->
//     64'hFFFF_FFFF_FFFF_FFFE,cout=0.
//  6. 10k random a,b,cin, random out_ready stalls; also W=8,CHUNK=8 (N=1)
//     -> every result equals {cout,sum}==a+b+cin.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// Shared types and sizing helpers for the sequential ripple-carry adder controller.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF     = 64;
  localparam int CHUNK_DEF = 8;

  function automatic int calc_n(input int w, input int chunk);
    return w / chunk;
  endfunction

  // A single-chunk operation still needs a 1-bit counter to stay legal.
  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// CHUNK-bit ripple-carry adder with carry-in, built from a chain of full-adder cells.
module rca_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle W-bit adder: one CHUNK-bit ripple slice reused over W/CHUNK cycles, LSB first.
// Optional subtract mode is enabled by defining RCA_SEQ_SUB_EN.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int N     = calc_n(W, CHUNK);
  localparam int CNT_W = calc_cnt_w(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((W % CHUNK) != 0 || CHUNK > W) begin : g_bad_cfg
    $error("rca_seq_ctrl: W must be a multiple of CHUNK and CHUNK <= W");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_sum_sh;
  logic             r_carry;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic [W-1:0]     w_sum_next;
  logic             w_accept;

  assign w_accept = in_valid && (r_state == IDLE);

  rca_slice #(.CHUNK(CHUNK)) u_slice (
    .i_a    (r_a_sh[CHUNK-1:0]),
    .i_b    (r_b_sh[CHUNK-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Each new chunk enters at the MSB end, so after N steps chunk 0 sits at the LSB.
  if (N > 1) begin : g_multi
    assign w_sum_next = {w_slice_sum, r_sum_sh[W-1:CHUNK]};
  end else begin : g_single
    assign w_sum_next = w_slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)       w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST)  w_state_nxt = DONE;
      DONE:    if (out_ready)      w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == RUN) || (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_a_sh <= a;
`ifdef RCA_SEQ_SUB_EN
      r_b_sh  <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
`else
      r_b_sh  <= b;
      r_carry <= cin;
`endif
    end else if (r_state == RUN) begin
      r_cnt    <= r_cnt + 1'b1;
      r_a_sh   <= r_a_sh >> CHUNK;
      r_b_sh   <= r_b_sh >> CHUNK;
      r_sum_sh <= w_sum_next;
      r_carry  <= w_slice_cout;
    end
  end

  assign sum  = r_sum_sh;
  assign cout = r_carry;

endmodule
